pwm_duty_ramp_ctrl: RTL

Soft-start / ramp sequencer that sits in front of the 10-step PWM generator and owns its duty-cycle setting. It accepts a target duty over a valid/ready handshake. It then walks duty_out one step at a time toward that target, with a programmable dwell between steps. It emits single-cycle inc/dec step strobes for the generator's step inputs or for logging, and flags completion.

---
 rtl/pwm_pkg.sv | 27 ++
 rtl/pwm_duty_ramp_ctrl_if.sv | 28 ++
 rtl/pwm_dwell_timer.sv | 32 +++
 rtl/pwm_duty_ramp_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty ramp sequencer.
// Duty width, duty ceiling, FSM state and ramp direction enums.
package pwm_pkg;

  localparam int DUTY_W = 4;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    STEP,
    DONE
  } ramp_state_t;

  typedef enum logic {
    UP,
    DOWN
  } ramp_dir_t;

  // Targets above the ceiling are pulled down to it.
  function automatic logic [DUTY_W-1:0] clamp_duty(
    input logic [DUTY_W-1:0] d
  );
    return (d > DUTY_MAX) ? DUTY_MAX : d;
  endfunction

endpackage

// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Target request channel of the duty ramp sequencer.
// Valid/ready handshake carrying target duty and dwell length.
interface pwm_duty_ramp_ctrl_if
  import pwm_pkg::*;
#(
  parameter int DWELL_W = 16
);

  logic               tgt_valid;
  logic               tgt_ready;
  logic [DUTY_W-1:0]  tgt_duty;
  logic [DWELL_W-1:0] dwell_cycles;

  modport master (
    output tgt_valid,
    output tgt_duty,
    output dwell_cycles,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_duty,
    input  dwell_cycles,
    output tgt_ready
  );

endinterface

// File: rtl/pwm_dwell_timer.sv
// Loadable down-counter timing the dwell between duty steps.
// Expires on the unheld edge where the count reaches one.
module pwm_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         hold,
  output logic         expire
);

  logic [W-1:0] count;

  assign expire = en && !hold &&
                  (count == W'(1));

  // Load wins; otherwise count down while enabled and not held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !hold &&
                 count != '0) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Soft-start ramp sequencer driving the PWM generator duty.
// Optional direct jump on zero dwell: PWM_RAMP_DIRECT_EN.
module pwm_duty_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int DWELL_W = 16,
  parameter logic [DUTY_W-1:0] RESET_DUTY = 4'd5
) (
  input  logic              clk,
  input  logic              reset,
  pwm_duty_ramp_ctrl_if.slave req,
  input  logic              hold,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty_out,
  output logic              inc_pulse,
  output logic              dec_pulse,
  output logic              busy,
  output logic              done
);

  ramp_state_t state, state_nxt;
  ramp_dir_t   dir_q, dir_nxt;

  logic [DUTY_W-1:0]  duty_nxt;
  logic [DUTY_W-1:0]  tgt_q, tgt_nxt;
  logic [DUTY_W-1:0]  tgt_in;
  logic [DWELL_W-1:0] dwell_q, dwell_nxt;
  logic [DWELL_W-1:0] dwell_in;
  logic [DWELL_W-1:0] tmr_val;
  logic               tmr_load;
  logic               tmr_en;
  logic               tmr_exp;
  logic               hs;
  logic               direct;

  assign req.tgt_ready = (state == IDLE);
  assign hs = req.tgt_valid &&
              (state == IDLE);

  assign tgt_in = clamp_duty(req.tgt_duty);
  assign dwell_in =
    (req.dwell_cycles == '0) ?
    DWELL_W'(1) : req.dwell_cycles;

`ifdef PWM_RAMP_DIRECT_EN
  assign direct = (req.dwell_cycles == '0);
`else
  assign direct = 1'b0;
`endif

  assign tmr_en = (state == DWELL) && !abort;

  pwm_dwell_timer #(
    .W(DWELL_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .hold     (hold),
    .expire   (tmr_exp)
  );

  // State, duty, latched target, direction and dwell registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      duty_out <= RESET_DUTY;
      tgt_q    <= RESET_DUTY;
      dir_q    <= UP;
      dwell_q  <= DWELL_W'(1);
    end else begin
      state    <= state_nxt;
      duty_out <= duty_nxt;
      tgt_q    <= tgt_nxt;
      dir_q    <= dir_nxt;
      dwell_q  <= dwell_nxt;
    end
  end

  // Next state, duty update and dwell timer reloads.
  always_comb begin
    state_nxt = state;
    duty_nxt  = duty_out;
    tgt_nxt   = tgt_q;
    dir_nxt   = dir_q;
    dwell_nxt = dwell_q;
    tmr_load  = 1'b0;
    tmr_val   = dwell_q;
    unique case (state)
      IDLE: begin
        if (hs) begin
          tgt_nxt   = tgt_in;
          dwell_nxt = dwell_in;
          if (tgt_in == duty_out) begin
            state_nxt = DONE;
          end else begin
            dir_nxt = (tgt_in > duty_out) ?
                      UP : DOWN;
            if (direct) begin
              duty_nxt  = tgt_in;
              state_nxt = STEP;
            end else begin
              tmr_load  = 1'b1;
              tmr_val   = dwell_in;
              state_nxt = DWELL;
            end
          end
        end
      end
      DWELL: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (tmr_exp) begin
          duty_nxt = (dir_q == UP) ?
                     duty_out + 1'b1 :
                     duty_out - 1'b1;
          state_nxt = STEP;
        end
      end
      STEP: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (duty_out == tgt_q) begin
          state_nxt = DONE;
        end else begin
          tmr_load  = 1'b1;
          state_nxt = DWELL;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state == DWELL) ||
                (state == STEP);
  assign done = (state == DONE);
  assign inc_pulse = (state == STEP) &&
                     (dir_q == UP);
  assign dec_pulse = (state == STEP) &&
                     (dir_q == DOWN);

endmodule
